// File: rtl/ray_pkg.sv
// Shared widths, FSM state encoding and hit record for the ray nearest-hit path.
package ray_pkg;

  localparam int unsigned TW_DEF  = 32;
  localparam int unsigned UVW_DEF = 16;
  localparam int unsigned IDW_DEF = 16;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  typedef struct packed {
    logic [TW_DEF-1:0]  t;
    logic [UVW_DEF-1:0] u;
    logic [UVW_DEF-1:0] v;
    logic [IDW_DEF-1:0] triid;
  } hit_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting lane at or after ptr, one-hot or zero.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_arbiter.sv
// Collects intersection candidates from NREQ lanes round-robin and keeps the
// nearest hit for the current ray; result is held until consumed.
module hit_arbiter
  import ray_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TW   = TW_DEF,
  parameter int unsigned UVW  = UVW_DEF,
  parameter int unsigned IDW  = IDW_DEF
) (
  input  logic                  clk,
  input  logic                  globalreset_n,
  input  logic                  ray_start,
  input  logic                  abort,
  output logic                  ray_busy,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_hit,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*TW-1:0]    req_t,
  input  logic [NREQ*UVW-1:0]   req_u,
  input  logic [NREQ*UVW-1:0]   req_v,
  input  logic [NREQ*IDW-1:0]   req_triid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TW-1:0]         res_t,
  output logic [UVW-1:0]        res_u,
  output logic [UVW-1:0]        res_v,
  output logic [IDW-1:0]        res_triid,
  output logic                  res_anyhit,
  output logic [CNT_W-1:0]      res_count
);

  localparam int unsigned      PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [TW-1:0]  t;
    logic [UVW-1:0] u;
    logic [UVW-1:0] v;
    logic [IDW-1:0] triid;
  } rec_t;

  state_e           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [NREQ-1:0]  lane_done;
  logic [NREQ-1:0]  req_pend;
  logic [NREQ-1:0]  gnt;
  rec_t             best;
  rec_t             sel;
  logic             sel_hit;
  logic             sel_last;
  logic             anyhit;
  logic [CNT_W-1:0] count;
  logic             collect;
  logic             xfer;
  logic             take;

  assign req_pend = req_valid & ~lane_done;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (req_pend),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Abort suppresses the grant in the same cycle so nothing is accepted.
  assign collect   = (state == ST_COLLECT) && !abort;
  assign req_ready = collect ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  // Granted lane index and payload
  always_comb begin
    gidx     = '0;
    sel      = '0;
    sel_hit  = 1'b0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx      = PW'(i);
        sel.t     = req_t[i*TW +: TW];
        sel.u     = req_u[i*UVW +: UVW];
        sel.v     = req_v[i*UVW +: UVW];
        sel.triid = req_triid[i*IDW +: IDW];
        sel_hit   = req_hit[i];
        sel_last  = req_last[i];
      end
    end
  end

  // Strictly nearer replaces; equal distance keeps the incumbent.
  assign take = xfer && sel_hit && (!anyhit || (sel.t < best.t));

  always_ff @(posedge clk or negedge globalreset_n) begin
    if (!globalreset_n) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (ray_start)    state_nxt = ST_COLLECT;
      ST_COLLECT: if (&lane_done)   state_nxt = ST_DONE;
      ST_DONE:    if (res_ready)    state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Per-ray accumulation registers
  always_ff @(posedge clk or negedge globalreset_n) begin
    if (!globalreset_n) begin
      ptr       <= '0;
      lane_done <= '0;
      best      <= '0;
      anyhit    <= 1'b0;
      count     <= '0;
    end else if (state == ST_IDLE) begin
      if (ray_start && !abort) begin
        ptr       <= '0;
        lane_done <= '0;
        best      <= '0;
        anyhit    <= 1'b0;
        count     <= '0;
      end
    end else if (xfer) begin
      ptr <= PW'((32'(gidx) + 32'd1) % NREQ);
      if (sel_last) lane_done <= lane_done | gnt;
      if (take)     best <= sel;
      if (sel_hit)  anyhit <= 1'b1;
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end
  end

  assign ray_busy   = (state != ST_IDLE);
  assign res_valid  = (state == ST_DONE);
  assign res_t      = best.t;
  assign res_u      = best.u;
  assign res_v      = best.v;
  assign res_triid  = best.triid;
  assign res_anyhit = anyhit;
  assign res_count  = count;

endmodule
